gf22_sram_banked_1w1r: RTL

- Parametrised 1-write/1-read memory wrapper built from single-port GF22 SRAM macros. It generalises the fixed 32-bit, 21-address-bit banked wrappers to arbitrary width, depth and lane count.
- Adds bank-conflict handling: a one-entry write buffer with back-pressure, plus read bypass from that buffer. A write and a read to the same bank in the same cycle never corrupt each other.
- Sits between accelerator private-local-memory ports and the technology macros.

---
 rtl/gf22_sram_pkg.sv | 23 ++
 rtl/gf22_sram_banked_1w1r_if.sv | 26 ++
 rtl/GF22_SRAM_SP_8192x32.sv | 20 ++
 rtl/gf22_sram_wbuf.sv | 95 +++++++++
 rtl/gf22_sram_banked_1w1r.sv | 131 +++++++++++++
 5 files changed

// File: rtl/gf22_sram_pkg.sv
// Shared constants and helpers for the banked GF22 SRAM wrappers.
// Bank/lane arithmetic lives here so wrapper and buffer agree on it.
package gf22_sram_pkg;

  localparam int MACRO_WIDTH      = 32;
  localparam int MACRO_ADDR_WIDTH = 13;

  function automatic int lane_cnt(input int dw);
    return dw / MACRO_WIDTH;
  endfunction

  function automatic int bank_cnt(input int aw, input int baw);
    return 1 << (aw - baw);
  endfunction

  function automatic int unsigned bank_of(
    input logic [31:0] a,
    input int          baw
  );
    return a >> baw;
  endfunction

endpackage

// File: rtl/gf22_sram_banked_1w1r_if.sv
// Write/read port bundle of the banked 1W1R SRAM wrapper.
// master = requester (accelerator PLM side), slave = wrapper.
interface gf22_sram_banked_1w1r_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
);
  logic                  CE0;
  logic [ADDR_WIDTH-1:0] A0;
  logic [DATA_WIDTH-1:0] D0;
  logic [DATA_WIDTH-1:0] WEM0;
  logic                  RDY0;
  logic                  CE1;
  logic [ADDR_WIDTH-1:0] A1;
  logic [DATA_WIDTH-1:0] Q1;
  logic                  QV1;

  modport master (
    output CE0, A0, D0, WEM0, CE1, A1,
    input  RDY0, Q1, QV1
  );

  modport slave (
    input  CE0, A0, D0, WEM0, CE1, A1,
    output RDY0, Q1, QV1
  );
endinterface

// File: rtl/GF22_SRAM_SP_8192x32.sv
// Behavioural model of the GF22 8192x32 single-port SRAM macro.
// Bit-masked write, registered read data, no reset on contents.
module GF22_SRAM_SP_8192x32 (
  input  logic        CLK,
  input  logic        CE,
  input  logic        WE,
  input  logic [12:0] A,
  input  logic [31:0] D,
  input  logic [31:0] WEM,
  output logic [31:0] Q
);
  logic [31:0] mem [8192];

  always_ff @(posedge CLK) begin
    if (CE) begin
      if (WE) mem[A] <= (mem[A] & ~WEM) | (D & WEM);
      else    Q      <= mem[A];
    end
  end
endmodule

// File: rtl/gf22_sram_wbuf.sv
// One-entry write buffer: absorbs writes that lose their bank to a
// read, drains on the first free cycle, and feeds read bypass.
module gf22_sram_wbuf
  import gf22_sram_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 16,
  parameter int BANK_ADDR_WIDTH = 13
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  ce0,
  input  logic [ADDR_WIDTH-1:0] a0,
  input  logic [DATA_WIDTH-1:0] d0,
  input  logic [DATA_WIDTH-1:0] wem0,
  input  logic                  ce1,
  input  logic [ADDR_WIDTH-1:0] a1,
  output logic                  rdy0,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  byp_hit,
  output logic [DATA_WIDTH-1:0] byp_data,
  output logic [DATA_WIDTH-1:0] byp_mask
);
  logic                  wb_valid;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [DATA_WIDTH-1:0] wb_mask;

  int unsigned rbank;
  logic        acc;
  logic        clash;
  logic        drain;
  logic        hit;

  always_comb begin
    rbank   = bank_of(32'(a1), BANK_ADDR_WIDTH);
    rdy0    = !wb_valid;
    acc     = ce0 && !wb_valid;
    clash   = ce1 &&
              (bank_of(32'(a0), BANK_ADDR_WIDTH) == rbank);
    drain   = wb_valid &&
              !(ce1 &&
                (bank_of(32'(wb_addr), BANK_ADDR_WIDTH) == rbank));
    hit     = ce1 && wb_valid && (wb_addr == a1);
    // acc implies an empty buffer, so drain and a new write never overlap
    wr_en   = drain || (acc && !clash);
    wr_addr = drain ? wb_addr : a0;
    wr_data = drain ? wb_data : d0;
    wr_mask = drain ? wb_mask : wem0;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      wb_mask  <= '0;
      byp_hit  <= 1'b0;
      byp_data <= '0;
      byp_mask <= '0;
    end else begin
      if (acc && clash) begin
        wb_valid <= 1'b1;
        wb_addr  <= a0;
        wb_data  <= d0;
        wb_mask  <= wem0;
      end else if (drain) begin
        wb_valid <= 1'b0;
      end
      byp_hit <= hit;
      if (hit) begin
        byp_data <= wb_data;
        byp_mask <= wb_mask;
      end
    end
  end

`ifndef SYNTHESIS
  logic pend_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) pend_q <= 1'b0;
    else       pend_q <= ce0 && !rdy0;
  end

  always_ff @(posedge CLK) begin
    if (RSTN)
      assert (!(pend_q && !ce0 && !rdy0))
      else $warning("gf22_sram_wbuf: CE0 dropped before RDY0");
  end
`endif
endmodule

// File: rtl/gf22_sram_banked_1w1r.sv
// Banked 1W1R wrapper over GF22 single-port macros; reads own their
// bank, colliding writes go through the one-entry buffer.
module gf22_sram_banked_1w1r
  import gf22_sram_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 16,
  parameter int BANK_ADDR_WIDTH = 13,
  parameter int OUT_REG         = 0
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  gf22_sram_banked_1w1r_if.slave  bus
);
  localparam int LN = lane_cnt(DATA_WIDTH);
  localparam int NB = bank_cnt(ADDR_WIDTH, BANK_ADDR_WIDTH);
  localparam int BW = ADDR_WIDTH - BANK_ADDR_WIDTH;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  byp_hit;
  logic [DATA_WIDTH-1:0] byp_data;
  logic [DATA_WIDTH-1:0] byp_mask;

  gf22_sram_wbuf #(
    .DATA_WIDTH      (DATA_WIDTH),
    .ADDR_WIDTH      (ADDR_WIDTH),
    .BANK_ADDR_WIDTH (BANK_ADDR_WIDTH)
  ) u_wbuf (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .ce0      (bus.CE0),
    .a0       (bus.A0),
    .d0       (bus.D0),
    .wem0     (bus.WEM0),
    .ce1      (bus.CE1),
    .a1       (bus.A1),
    .rdy0     (bus.RDY0),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_mask  (wr_mask),
    .byp_hit  (byp_hit),
    .byp_data (byp_data),
    .byp_mask (byp_mask)
  );

  logic [MACRO_WIDTH-1:0] mq [NB][LN];

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic                        rd_b;
    logic                        wr_b;
    logic [MACRO_ADDR_WIDTH-1:0] ad_b;

    always_comb begin
      rd_b = bus.CE1 &&
             (bank_of(32'(bus.A1), BANK_ADDR_WIDTH) == 32'(b));
      wr_b = wr_en &&
             (bank_of(32'(wr_addr), BANK_ADDR_WIDTH) == 32'(b));
      ad_b = rd_b ? MACRO_ADDR_WIDTH'(bus.A1[BANK_ADDR_WIDTH-1:0])
                  : MACRO_ADDR_WIDTH'(wr_addr[BANK_ADDR_WIDTH-1:0]);
    end

    for (genvar l = 0; l < LN; l++) begin : g_lane
      GF22_SRAM_SP_8192x32 u_mac (
        .CLK (CLK),
        .CE  (rd_b || wr_b),
        .WE  (wr_b),
        .A   (ad_b),
        .D   (wr_data[l*MACRO_WIDTH +: MACRO_WIDTH]),
        .WEM (wr_mask[l*MACRO_WIDTH +: MACRO_WIDTH]),
        .Q   (mq[b][l])
      );
    end

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
      if (RSTN)
        assert (!(rd_b && wr_b))
        else $fatal(1, "gf22_sram_banked_1w1r: bank %0d double request", b);
    end
`endif
  end

  logic [BW-1:0]         rsel_q;
  logic                  rv_q;
  logic [DATA_WIDTH-1:0] mux_q;
  logic [DATA_WIDTH-1:0] rd_d;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rsel_q <= '0;
      rv_q   <= 1'b0;
    end else begin
      rv_q <= bus.CE1;
      if (bus.CE1) rsel_q <= bus.A1[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
    end
  end

  always_comb begin
    mux_q = '0;
    for (int l = 0; l < LN; l++)
      mux_q[l*MACRO_WIDTH +: MACRO_WIDTH] = mq[rsel_q][l];
    rd_d = mux_q;
    if (byp_hit) rd_d = (mux_q & ~byp_mask) | (byp_data & byp_mask);
    if (!rv_q)   rd_d = '0;
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] q_r;
    logic                  qv_r;

    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        q_r  <= '0;
        qv_r <= 1'b0;
      end else begin
        q_r  <= rd_d;
        qv_r <= rv_q;
      end
    end

    assign bus.Q1  = q_r;
    assign bus.QV1 = qv_r;
  end else begin : g_nreg
    assign bus.Q1  = rd_d;
    assign bus.QV1 = rv_q;
  end
endmodule
